// File: rtl/booth_pkg.sv
// Shared types and digit recoding for the sequential radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_e;

  typedef logic signed [2:0] booth_digit_t;

  localparam booth_digit_t BD_ZERO = 3'sd0;
  localparam booth_digit_t BD_P1   = 3'sd1;
  localparam booth_digit_t BD_P2   = 3'sd2;
  localparam booth_digit_t BD_N1   = -3'sd1;
  localparam booth_digit_t BD_N2   = -3'sd2;

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_t booth_encode(input logic [2:0] w);
    case (w)
      3'b001, 3'b010: return BD_P1;
      3'b011:         return BD_P2;
      3'b100:         return BD_N2;
      3'b101, 3'b110: return BD_N1;
      default:        return BD_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// One radix-4 Booth partial-product generator: window + extended multiplicand -> signed term.
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              [2:0]       window,
  input  logic signed       [WIDTH+1:0] a_ext,
  output logic signed       [WIDTH+2:0] term
);

  booth_digit_t             digit;
  logic signed [WIDTH+2:0]  a_wide;

  always_comb begin
    digit  = booth_encode(window);
    a_wide = {a_ext[WIDTH+1], a_ext};
    case (digit)
      BD_P1:   term = a_wide;
      BD_P2:   term = a_wide <<< 1;
      BD_N1:   term = -a_wide;
      BD_N2:   term = -(a_wide <<< 1);
      default: term = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier retiring DIGITS_PER_CYCLE digits per clock,
// with valid/ready handshakes on operands and product.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int EXT_W  = WIDTH + 2;
  localparam int TERM_W = WIDTH + 3;
  localparam int WIN_W  = WIDTH + 3;
  localparam int ACC_W  = 2*WIDTH + 2;
  localparam int NDIG   = WIDTH/2 + 1;
  localparam int CNT_W  = $clog2(NDIG + DIGITS_PER_CYCLE + 1);

  booth_state_e               state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [EXT_W-1:0]    a_q, a_d;
  logic signed [WIN_W-1:0]    win_q, win_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [2*WIDTH-1:0]         product_q, product_d;
  logic signed [TERM_W-1:0]   term [DIGITS_PER_CYCLE];
  logic                       accept, last;

  function automatic logic signed [ACC_W-1:0] sext_term(input logic signed [TERM_W-1:0] t);
    return {{(ACC_W-TERM_W){t[TERM_W-1]}}, t};
  endfunction

  for (genvar j = 0; j < DIGITS_PER_CYCLE; j++) begin : g_digit
    booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
      .window (win_q[2*j+2 -: 3]),
      .a_ext  (a_q),
      .term   (term[j])
    );
  end

  // Digits past NDIG only appear when DIGITS_PER_CYCLE does not divide NDIG; they contribute nothing.
  always_comb begin
    acc_sum = acc_q;
    for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
      if (int'(cnt_q) + j < NDIG)
        acc_sum = acc_sum + (sext_term(term[j]) <<< (2*(int'(cnt_q) + j)));
    end
  end

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;
  assign accept    = in_valid && in_ready;
  assign last      = (int'(cnt_q) + DIGITS_PER_CYCLE >= NDIG);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    win_d     = win_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(DIGITS_PER_CYCLE);
        win_d = win_q >>> (2*DIGITS_PER_CYCLE);
        if (last) begin
          state_d   = DONE;
          product_d = acc_sum[2*WIDTH-1:0];
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: ;
    endcase
    // A pop in DONE and a new accept can share the same edge.
    if (accept) begin
      state_d = CALC;
      cnt_d   = '0;
      acc_d   = '0;
      a_d     = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
      win_d   = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    win_q <= win_d;
    acc_q <= acc_d;
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: one instance per DIGITS_PER_CYCLE setting, a transaction-level
// model checked every cycle, and directed vectors with hand-computed products.
module tb_booth_mult_seq;

  localparam int W    = 32;
  localparam int NDIG = W/2 + 1;

  logic        clk = 1'b0;
  logic        rst_s        [2];
  logic        in_valid_s   [2];
  logic        in_ready_s   [2];
  logic [31:0] a_s          [2];
  logic [31:0] b_s          [2];
  logic        is_signed_s  [2];
  logic        out_valid_s  [2];
  logic        out_ready_s  [2];
  logic [63:0] prod_s       [2];
  logic        busy_s       [2];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(W), .DIGITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .multiplicand(a_s[0]), .multiplier(b_s[0]), .is_signed(is_signed_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .product(prod_s[0]), .busy(busy_s[0])
  );

  booth_mult_seq #(.WIDTH(W), .DIGITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .multiplicand(a_s[1]), .multiplier(b_s[1]), .is_signed(is_signed_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .product(prod_s[1]), .busy(busy_s[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  function automatic int iter_of(input int k);
    int dpc = k + 1;
    return (NDIG + dpc - 1) / dpc;
  endfunction

  function automatic int iter_lit(input int k);
    return (k == 0) ? 17 : 9;
  endfunction

  // Transaction model: one op in flight, result visible ITER edges after its accept edge.
  bit          seen_rst   [2] = '{0, 0};
  bit          m_inflight [2] = '{0, 0};
  int          m_start    [2] = '{0, 0};
  logic [63:0] m_exp      [2];
  logic [63:0] m_prod     [2] = '{64'd0, 64'd0};
  bit          mon_ov, mon_ir;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (m_inflight[k] && cyc == m_start[k] + iter_of(k) + 1) m_prod[k] = m_exp[k];
      mon_ov = m_inflight[k] && (cyc >= m_start[k] + iter_of(k) + 1);
      mon_ir = !m_inflight[k] || (mon_ov && out_ready_s[k]);
      if (seen_rst[k]) begin
        chk($sformatf("mon%0d_out_valid", k), 64'(out_valid_s[k]), 64'(mon_ov));
        chk($sformatf("mon%0d_in_ready", k),  64'(in_ready_s[k]),  64'(mon_ir));
        chk($sformatf("mon%0d_busy", k),      64'(busy_s[k]),      64'(m_inflight[k]));
        chk($sformatf("mon%0d_product", k),   prod_s[k],           m_prod[k]);
      end
      if (rst_s[k]) begin
        m_inflight[k] = 0;
        m_prod[k]     = '0;
        seen_rst[k]   = 1;
      end else begin
        if (mon_ov && out_ready_s[k]) m_inflight[k] = 0;
        if (in_valid_s[k] && mon_ir) begin
          m_inflight[k] = 1;
          m_start[k]    = cyc;
          m_exp[k]      = ref_mul(a_s[k], b_s[k], is_signed_s[k]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k, input string nm);
    int n = 0;
    while (!in_ready_s[k] && n < 50) begin step(); n++; end
    chk({nm, "_in_ready"}, 64'(in_ready_s[k]), 64'd1);
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    while (!out_valid_s[k] && lat < 40) begin step(); lat++; end
  endtask

  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp, input string nm);
    int lat;
    a_s[k] = a; b_s[k] = b; is_signed_s[k] = s;
    in_valid_s[k] = 1'b1; out_ready_s[k] = 1'b0;
    wait_ready(k, nm);
    step();
    in_valid_s[k] = 1'b0;
    a_s[k] = $urandom; b_s[k] = $urandom; is_signed_s[k] = ~s;
    wait_valid(k, lat);
    chk({nm, "_latency"}, 64'(lat), 64'(iter_lit(k)));
    chk(nm, prod_s[k], exp);
    out_ready_s[k] = 1'b1;
    step();
    out_ready_s[k] = 1'b0;
  endtask

  task automatic backpressure(input int k);
    int lat;
    a_s[k] = 32'd5; b_s[k] = 32'd7; is_signed_s[k] = 1'b0;
    in_valid_s[k] = 1'b1; out_ready_s[k] = 1'b0;
    wait_ready(k, "bp_first");
    step();
    in_valid_s[k] = 1'b0;
    wait_valid(k, lat);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_out_valid", 64'(out_valid_s[k]), 64'd1);
      chk("bp_hold_in_ready",  64'(in_ready_s[k]),  64'd0);
      chk("bp_hold_product",   prod_s[k],           64'd35);
      step();
    end
    a_s[k] = 32'hFFFFFFFE; b_s[k] = 32'd9; is_signed_s[k] = 1'b1;
    in_valid_s[k] = 1'b1; out_ready_s[k] = 1'b1;
    step();
    in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0;
    chk("bp_pop_out_valid", 64'(out_valid_s[k]), 64'd0);
    chk("bp_accept_busy",   64'(busy_s[k]),      64'd1);
    wait_valid(k, lat);
    chk("bp_second_latency", 64'(lat), 64'(iter_lit(k)));
    chk("bp_second_product", prod_s[k], 64'hFFFFFFFFFFFFFFEE);
    out_ready_s[k] = 1'b1;
    step();
    out_ready_s[k] = 1'b0;
  endtask

  task automatic reset_mid_op(input int k);
    a_s[k] = 32'h1234; b_s[k] = 32'h5678; is_signed_s[k] = 1'b1;
    in_valid_s[k] = 1'b1; out_ready_s[k] = 1'b0;
    wait_ready(k, "rst_op");
    step();
    in_valid_s[k] = 1'b0;
    repeat (4) step();
    rst_s[k] = 1'b1;
    step();
    rst_s[k] = 1'b0;
    chk("rst_in_ready",  64'(in_ready_s[k]),  64'd1);
    chk("rst_out_valid", 64'(out_valid_s[k]), 64'd0);
    chk("rst_busy",      64'(busy_s[k]),      64'd0);
    chk("rst_product",   prod_s[k],           64'd0);
    repeat (iter_lit(k) + 2) begin
      chk("rst_no_valid", 64'(out_valid_s[k]), 64'd0);
      step();
    end
    do_op(k, 32'd3, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFFFFFFFFF1, "rst_fresh_3xm5");
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h7FFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_ops(input int k, input int nops);
    int done_ops = 0;
    int guard = 0;
    bit pend = 0;
    while (done_ops < nops && guard < 20000) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1;
        a_s[k] = pick(); b_s[k] = pick(); is_signed_s[k] = 1'($urandom_range(0, 1));
      end
      in_valid_s[k]  = pend;
      out_ready_s[k] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pend && in_ready_s[k]) begin pend = 0; done_ops++; end
      step();
      guard++;
    end
    in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b1;
    repeat (iter_lit(k) + 3) step();
    out_ready_s[k] = 1'b0;
    chk("rand_ops_count", 64'(done_ops), 64'(nops));
    chk("rand_drained_busy", 64'(busy_s[k]), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0;
      a_s[k] = '0; b_s[k] = '0; is_signed_s[k] = 1'b0;
    end
    repeat (3) step();
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("reset_in_ready",  64'(in_ready_s[k]),  64'd1);
      chk("reset_out_valid", 64'(out_valid_s[k]), 64'd0);
      chk("reset_busy",      64'(busy_s[k]),      64'd0);
      chk("reset_product",   prod_s[k],           64'd0);
    end
    for (int k = 0; k < 2; k++) begin
      do_op(k, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, "s_m1xm1");
      do_op(k, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "u_maxxmax");
      do_op(k, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, "s_minxmin");
      do_op(k, 32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000, "s_minx1");
      do_op(k, 32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000, "u_msbx2");
      do_op(k, 32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000, "s_maxxmin");
      backpressure(k);
      reset_mid_op(k);
      rand_ops(k, 400);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
    $fatal(1);
  end

endmodule
